mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-stage load/store unit: consumes the size/sign flags (lb, lh, lbu, lhu) from the ALU decoder and the
//  ALU-computed address, and runs a req/ack transaction to data memory.
//  Generates byte enables and lane-aligned store data; sign/zero-extends load data; stalls the pipeline
//  until done. Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  default 16  cycles in REQ without dmem_ack before bus_err; must be >= 2
//  CNT_W           default 5   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  memreadM     in   1   load in M stage
//  memwriteM    in   1   store in M stage
//  lb, lh       in   1   byte/half size flags (both 0 = word)
//  lbu, lhu     in   1   unsigned variants (accompanied by lb/lh = 1)
//  addrM        in   32  effective address from ALU
//  wdataM       in   32  store data, value in low bits
//  dmem_req     out  1   memory request, held until dmem_ack
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word-aligned address ({addrM[31:2],2'b00})
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   transaction complete; dmem_rdata valid on same cycle for reads
//  dmem_rdata   in   32  read word
//  stallM       out  1   hold IF..M pipeline registers
//  rdataM       out  32  extended load result, valid while state==DONE
//  misaligned   out  1   1-cycle pulse: misaligned access, no request issued
//  bus_err      out  1   1-cycle pulse: timeout, transaction abandoned
// BEHAVIOUR
//  Reset: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, stallM=0, rdataM=0, misaligned=0, bus_err=0, counter=0.
//  Reset mid-transaction drops dmem_req on the next edge; the memory side tolerates the abandon.
//  op = memreadM|memwriteM; memreadM and memwriteM are never both 1.
//  Size: byte if lb, half if lh, else word. Misaligned if (half & addrM[0]) | (word & addrM[1:0]!=0).
//  FSM IDLE/REQ/DONE:
//   IDLE: op & ~misal -> REQ, latch addr/we/be/wdata/size/sign, stallM=1 combinationally same cycle.
//         op & misal  -> stay IDLE, misaligned pulse next cycle, stallM=0 (trap handled downstream).
//   REQ:  dmem_req=1, stallM=1; dmem_ack -> DONE, capture extended rdata into rdataM (loads).
//         counter==TIMEOUT_CYCLES-1 without ack -> IDLE, bus_err pulse, rdataM=0, stallM=0 on exit.
//   DONE: stallM=0 for exactly one cycle (pipeline advances); -> IDLE. No re-issue of the same op.
//  Latency: ack in first REQ cycle => stall 2 cycles total (IDLE-detect + REQ); +1 per wait cycle.
//  Counter cleared on IDLE->REQ; increments each REQ cycle; saturates, never wraps.
//  Store lanes: byte -> be=1<<addr[1:0], wdata={4{wdataM[7:0]}}; half -> be=addr[1]?1100:0011,
//   wdata={2{wdataM[15:0]}}; word -> be=1111, wdata=wdataM. Load: be as per size; dmem_we=0.
//  Load extract: byte lane = rdata[8*addr[1:0]+:8]; half lane = rdata[16*addr[1]+:16];
//   sign-extend unless lbu/lhu; word passes through.
//  Outputs registered except stallM (needed same cycle as the new op in IDLE).
//  Inputs ignored while in REQ/DONE (held stable by stallM anyway).
// STRUCTURE
//  Shared package riscv_pkg: typedef enum logic[1:0] {MS_IDLE,MS_REQ,MS_DONE} memst_t;
//   typedef enum logic[1:0] {SZ_B,SZ_H,SZ_W} memsz_t; constants BE_BYTE0, BE_HALF_LO/HI, BE_WORD.
//  One sub-module: load_extend (comb: rdata, addr[1:0], size, unsigned -> 32-bit result);
//   FSM, counter and store lane logic stay in this module.
// TESTING
//  lw addr=0x100, ack on 1st REQ cycle, rdata=0xDEADBEEF -> rdataM=0xDEADBEEF, stallM high 2 cycles, be=1111.
//  lb addr=0x103, rdata=0x80FF_0000 -> be=1000, rdataM=0xFFFFFF80; same with lbu -> 0x00000080.
//  sh addr=0x102 wdataM=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD; lhu addr=0x102 rdata=0x8001_0000 -> 0x00008001.
//  lw addr=0x101 -> no dmem_req, misaligned pulse 1 cycle, stallM never asserted.
//  ack withheld, TIMEOUT_CYCLES=16 -> dmem_req high exactly 16 cycles, bus_err pulse, back to IDLE.
//  reset asserted in REQ cycle 3 with ack pending -> dmem_req=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared memory-stage types, byte-enable constants and lane helpers.
// Used by the load/store stage, its load extender and the data-memory interface.
package riscv_pkg;

    typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_DONE} memst_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} memsz_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic memsz_t decode_size(input logic lb, input logic lh);
        if (lb)      return SZ_B;
        else if (lh) return SZ_H;
        else         return SZ_W;
    endfunction

    function automatic logic [3:0] lane_be(input memsz_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return BE_BYTE0 << a;
            SZ_H:    return a[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus; request side held until ack, read data valid with ack.
// master = load/store stage, slave = memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
// Purely combinational; no flow control.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  memsz_t      i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_result = i_rdata;
        case (i_size)
            SZ_B:    o_result = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_result = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Load/store unit: one req/ack transaction per memory op; stalls from op detect until ack.
// Ack in first REQ cycle gives 2 stall cycles, +1 per wait cycle; times out after TIMEOUT_CYCLES.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memreadM,
    input  logic               memwriteM,
    input  logic               lb,
    input  logic               lh,
    input  logic               lbu,
    input  logic               lhu,
    input  logic [31:0]        addrM,
    input  logic [31:0]        wdataM,
    mem_access_stage_if.master dmem,
    output logic               stallM,
    output logic [31:0]        rdataM,
    output logic               misaligned,
    output logic               bus_err
);
    memst_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req, r_we, r_uns, r_misal, r_buserr;
    logic [3:0]       r_be;
    logic [31:0]      r_addr, r_wdata, r_rdata;
    logic [1:0]       r_addr_lo;
    memsz_t           r_size;

    logic             w_op, w_misal, w_timeout, w_start;
    memsz_t           w_size;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata, w_ext;

    assign w_op      = memreadM | memwriteM;
    assign w_size    = decode_size(lb, lh);
    assign w_misal   = ((w_size == SZ_H) & addrM[0]) |
                       ((w_size == SZ_W) & (addrM[1:0] != 2'b00));
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_start   = (r_state == MS_IDLE) & w_op & ~w_misal;
    assign w_be      = lane_be(w_size, addrM[1:0]);

    always_comb begin
        w_wdata = wdataM;
        case (w_size)
            SZ_B:    w_wdata = {4{wdataM[7:0]}};
            SZ_H:    w_wdata = {2{wdataM[15:0]}};
            default: w_wdata = wdataM;
        endcase
    end

    // stallM is the only combinational output: it must hold the pipeline in the detect cycle.
    always_comb begin
        w_next = r_state;
        stallM = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_start) begin
                    w_next = MS_REQ;
                    stallM = 1'b1;
                end
            end
            MS_REQ: begin
                stallM = 1'b1;
                if (dmem.dmem_ack)  w_next = MS_DONE;
                else if (w_timeout) w_next = MS_IDLE;
            end
            MS_DONE: w_next = MS_IDLE;
            default: w_next = MS_IDLE;
        endcase
    end

    load_extend u_load_extend (
        .i_rdata    (dmem.dmem_rdata),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_result   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= MS_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_addr_lo <= 2'b00;
            r_size    <= SZ_W;
            r_uns     <= 1'b0;
            r_rdata   <= 32'h0;
            r_misal   <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_req    <= (w_next == MS_REQ);
            r_misal  <= (r_state == MS_IDLE) & w_op & w_misal;
            r_buserr <= (r_state == MS_REQ) & ~dmem.dmem_ack & w_timeout;
            if (w_start) begin
                r_cnt     <= '0;
                r_we      <= memwriteM;
                r_be      <= w_be;
                r_addr    <= {addrM[31:2], 2'b00};
                r_wdata   <= w_wdata;
                r_addr_lo <= addrM[1:0];
                r_size    <= w_size;
                r_uns     <= lbu | lhu;
            end else if (r_state == MS_REQ) begin
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                if (dmem.dmem_ack)  r_rdata <= r_we ? 32'h0 : w_ext;
                else if (w_timeout) r_rdata <= 32'h0;
            end
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign rdataM          = r_rdata;
    assign misaligned      = r_misal;
    assign bus_err         = r_buserr;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table of memory ops with a memory responder and
// rdataM scoreboard, plus reset, timeout and reset-mid-transaction sequences.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM, memwriteM, lb, lh, lbu, lhu;
    logic [31:0] addrM, wdataM;
    logic        stallM;
    logic [31:0] rdataM;
    logic        misaligned, bus_err;

    mem_access_stage_if dmem_bus();

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .lb         (lb),
        .lh         (lh),
        .lbu        (lbu),
        .lhu        (lhu),
        .addrM      (addrM),
        .wdataM     (wdataM),
        .dmem       (dmem_bus),
        .stallM     (stallM),
        .rdataM     (rdataM),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, b, h, u;
        logic [31:0] addr, wdata, rdata;
        int          dly;
        logic [3:0]  be;
        logic [31:0] exp_wdata, exp_rdata;
        logic        misal;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(logic rd, logic wr, logic b, logic h, logic u,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                int dly, logic [3:0] be, logic [31:0] ewd, logic [31:0] erd,
                                logic misal);
        vec_t v;
        v.rd = rd; v.wr = wr; v.b = b; v.h = h; v.u = u;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly; v.be = be;
        v.exp_wdata = ewd; v.exp_rdata = erd; v.misal = misal;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_op();
        memreadM = 0; memwriteM = 0; lb = 0; lh = 0; lbu = 0; lhu = 0;
        addrM = 32'h0; wdataM = 32'h0;
    endtask

    task automatic drive_op(input vec_t v);
        memreadM = v.rd; memwriteM = v.wr;
        lb = v.b; lh = v.h; lbu = v.b & v.u; lhu = v.h & v.u;
        addrM = v.addr; wdataM = v.wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          stalls = 0, reqs = 0, pulses = 0;
        bit          acked = 0, done = 0;
        logic [31:0] e;
        @(negedge clk);
        drive_op(v);
        if (!v.misal) sb_q.push_back(v.exp_rdata);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (stallM) stalls++;
            if (misaligned) pulses++;
            if (dmem_bus.dmem_req) begin
                if (reqs == 0) begin
                    chk($sformatf("v%0d_addr", idx), dmem_bus.dmem_addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d_be", idx), 32'(dmem_bus.dmem_be), 32'(v.be));
                    chk($sformatf("v%0d_we", idx), 32'(dmem_bus.dmem_we), 32'(v.wr));
                    if (v.wr) chk($sformatf("v%0d_wdata", idx), dmem_bus.dmem_wdata, v.exp_wdata);
                end
                dmem_bus.dmem_ack   = (reqs == v.dly);
                dmem_bus.dmem_rdata = (reqs == v.dly) ? v.rdata : ~v.rdata;
                if (reqs == v.dly) acked = 1;
                reqs++;
            end else begin
                dmem_bus.dmem_ack = 0;
                if (acked && !done) begin
                    done = 1;
                    e = sb_q.pop_front();
                    if (v.rd) chk($sformatf("v%0d_rdataM", idx), rdataM, e);
                    clear_op();
                end
            end
            if (v.misal && c == 1) clear_op();
            @(negedge clk);
        end
        chk($sformatf("v%0d_stalls", idx), 32'(stalls), v.misal ? 32'd0 : 32'(v.dly + 2));
        chk($sformatf("v%0d_reqs", idx), 32'(reqs), v.misal ? 32'd0 : 32'(v.dly + 1));
        chk($sformatf("v%0d_misal_pulses", idx), 32'(pulses), v.misal ? 32'd1 : 32'd0);
        if (!v.misal && !done) begin
            checks++; errors++;
            $display("FAIL v%0d_no_done: transaction did not complete within bound", idx);
            if (sb_q.size() > 0) sb_q.delete(0);
            clear_op();
            dmem_bus.dmem_ack = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs, errs, last_req;
        vec_t v;

        vecs[0]  = mk(1,0,0,0,0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
        vecs[1]  = mk(1,0,1,0,0, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
        vecs[2]  = mk(1,0,1,0,1, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h0,        32'h00000080, 0);
        vecs[3]  = mk(0,1,0,1,0, 32'h102, 32'h1234ABCD, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        0);
        vecs[4]  = mk(1,0,0,1,1, 32'h102, 32'h0,        32'h80010000, 0, 4'b1100, 32'h0,        32'h00008001, 0);
        vecs[5]  = mk(1,0,0,0,0, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[6]  = mk(1,0,0,1,0, 32'h100, 32'h0,        32'h12348765, 2, 4'b0011, 32'h0,        32'hFFFF8765, 0);
        vecs[7]  = mk(0,1,1,0,0, 32'h101, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0);
        vecs[8]  = mk(1,0,0,1,0, 32'h103, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[9]  = mk(0,1,0,0,0, 32'h204, 32'hCAFEF00D, 32'h0,        3, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
        vecs[10] = mk(0,1,0,0,0, 32'h202, 32'h00000001, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[11] = mk(1,0,1,0,1, 32'h102, 32'h0,        32'h00AB0000, 0, 4'b0100, 32'h0,        32'h000000AB, 0);
        vecs[12] = mk(1,0,1,0,0, 32'h101, 32'h0,        32'h00007F00, 1, 4'b0010, 32'h0,        32'h0000007F, 0);

        reset = 1;
        clear_op();
        dmem_bus.dmem_ack   = 0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   32'(dmem_bus.dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_bus.dmem_we),  32'd0);
        chk("rst_be",    32'(dmem_bus.dmem_be),  32'd0);
        chk("rst_stall", 32'(stallM),            32'd0);
        chk("rst_rdata", rdataM,                 32'h0);
        chk("rst_misal", 32'(misaligned),        32'd0);
        chk("rst_buserr",32'(bus_err),           32'd0);
        reset = 0;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset in the third REQ cycle of a store while ack is still pending.
        v = mk(0,1,0,0,0, 32'h400, 32'h00000055, 32'h0, 0, 4'b1111, 32'h55, 32'h0, 0);
        @(negedge clk);
        drive_op(v);
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (dmem_bus.dmem_req) reqs++;
            if (reqs == 3) begin
                reset = 1;
                clear_op();
                break;
            end
            @(negedge clk);
        end
        chk("mid_rst_reached_req3", 32'(reqs), 32'd3);
        @(negedge clk);
        #1;
        chk("mid_rst_req",    32'(dmem_bus.dmem_req), 32'd0);
        chk("mid_rst_we",     32'(dmem_bus.dmem_we),  32'd0);
        chk("mid_rst_be",     32'(dmem_bus.dmem_be),  32'd0);
        chk("mid_rst_stall",  32'(stallM),            32'd0);
        chk("mid_rst_rdata",  rdataM,                 32'h0);
        chk("mid_rst_misal",  32'(misaligned),        32'd0);
        chk("mid_rst_buserr", 32'(bus_err),           32'd0);
        reset = 0;

        run_vec(100, vecs[0]);

        // Ack withheld: request must last exactly TO cycles, then one bus_err pulse.
        v = mk(1,0,0,0,0, 32'h300, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0, 0);
        @(negedge clk);
        drive_op(v);
        reqs = 0; errs = 0; last_req = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmem_bus.dmem_req) begin
                reqs++;
                last_req = c;
            end
            if (bus_err) begin
                errs++;
                if (errs == 1) begin
                    chk("to_rdata_cleared", rdataM, 32'h0);
                    chk("to_err_after_last_req", 32'(c), 32'(last_req + 1));
                    clear_op();
                end
            end
            @(negedge clk);
        end
        #1;
        chk("to_req_cycles",  32'(reqs),              32'(TO));
        chk("to_err_pulses",  32'(errs),              32'd1);
        chk("to_idle_stall",  32'(stallM),            32'd0);
        chk("to_idle_req",    32'(dmem_bus.dmem_req), 32'd0);

        run_vec(101, vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
